// File: rtl/gx4000_asic_ram_port.sv
// ASIC RAM responder: single-port RAM shared between the sprite engine (fixed one-cycle
// latency, absolute priority) and the Z80 (posted write FIFO, one buffered read).
module gx4000_asic_ram_port #(
  parameter int unsigned       ADDR_W      = 14,
  parameter logic [15:0]       CPU_BASE    = 16'h4000,
  parameter logic [ADDR_W-1:0] PAT_TOP     = 14'h0FFF,
  parameter int unsigned       WFIFO_DEPTH = 2
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              asic_unlocked,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_data,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  output logic [7:0]        cpu_q,
  output logic              cpu_q_valid,
  output logic              cpu_busy,
  output logic              err_drop,
  input  logic [ADDR_W-1:0] asic_ram_addr,
  input  logic              asic_ram_rd,
  input  logic              asic_ram_wr,
  input  logic [7:0]        asic_ram_din,
  output logic [7:0]        asic_ram_q,
  output logic              asic_ram_q_vld
);
  localparam int unsigned PW = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(WFIFO_DEPTH);
  localparam logic [16:0] WIN_LO = {1'b0, CPU_BASE};
  localparam logic [16:0] WIN_HI = WIN_LO + (17'd1 << ADDR_W);

  typedef struct packed {
    logic [ADDR_W-1:0] off;
    logic [7:0]        data;
  } wentry_t;

  typedef enum logic [1:0] {IDLE, RD_PEND, RD_DATA} rd_state_e;

  // CPU address decode
  logic              hit, wr_acc, rd_acc, drop;
  logic [16:0]       cpu_addr_x;
  logic [ADDR_W-1:0] cpu_off;

  // registered state
  rd_state_e         state_q;
  logic [ADDR_W-1:0] rd_off_q;
  logic [7:0]        cpu_q_q, asic_ram_q_q;
  logic              cpu_q_valid_q, cpu_busy_q, err_drop_q, asic_ram_q_vld_q;

  // write FIFO
  wentry_t           fifo_q [WFIFO_DEPTH];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  wentry_t           head;

  // RAM port
  logic [7:0]        mem [2**ADDR_W];
  logic              sprite_act, drain, rd_svc, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata, ram_wstore, ram_rdata;

  assign cpu_addr_x = {1'b0, cpu_addr};
  assign hit        = asic_unlocked && (cpu_addr_x >= WIN_LO) && (cpu_addr_x < WIN_HI);
  assign cpu_off    = ADDR_W'(cpu_addr - CPU_BASE);

  // Busy is a registered view of full/pending, so it already gates strobes this cycle.
  assign wr_acc = hit && cpu_wr && !cpu_busy_q;
  assign rd_acc = hit && cpu_rd && !cpu_wr && !cpu_busy_q;
  assign drop   = hit && ((cpu_busy_q && (cpu_wr || cpu_rd)) || (cpu_wr && cpu_rd));

  assign sprite_act = asic_ram_rd || asic_ram_wr;
  assign drain      = !sprite_act && (cnt_q != '0);
  assign rd_svc     = !sprite_act && (cnt_q == '0) && (state_q == RD_PEND);
  assign head       = fifo_q[rptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (wr_acc && !drain)      cnt_d = cnt_q + 1'b1;
    else if (!wr_acc && drain) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_acc) begin
        fifo_q[wptr_q] <= {cpu_off, cpu_data};
        wptr_q         <= wptr_q + 1'b1;
      end
      if (drain) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // One access per cycle: sprite, then FIFO head, then the pending CPU read.
  always_comb begin
    ram_addr  = asic_ram_addr;
    ram_we    = 1'b0;
    ram_wdata = asic_ram_din;
    if (sprite_act) begin
      ram_we = asic_ram_wr;
    end else if (drain) begin
      ram_addr  = head.off;
      ram_we    = 1'b1;
      ram_wdata = head.data;
    end else if (rd_svc) begin
      ram_addr = rd_off_q;
    end
    if (reset) ram_we = 1'b0;
  end

  assign ram_wstore = (ram_addr <= PAT_TOP) ? {4'h0, ram_wdata[3:0]} : ram_wdata;
  assign ram_rdata  = mem[ram_addr];

  // Read is combinational off the old contents, giving read-before-write on rd+wr.
  always_ff @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_wstore;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      asic_ram_q_q     <= '0;
      asic_ram_q_vld_q <= 1'b0;
    end else begin
      asic_ram_q_vld_q <= asic_ram_rd;
      if (asic_ram_rd) asic_ram_q_q <= ram_rdata;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= IDLE;
      rd_off_q      <= '0;
      cpu_q_q       <= '0;
      cpu_q_valid_q <= 1'b0;
      cpu_busy_q    <= 1'b0;
      err_drop_q    <= 1'b0;
    end else begin
      cpu_q_valid_q <= 1'b0;
      if (drop) err_drop_q <= 1'b1;
      case (state_q)
        IDLE: begin
          cpu_busy_q <= (cnt_d == FULL_CNT);
          if (rd_acc) begin
            state_q    <= RD_PEND;
            rd_off_q   <= cpu_off;
            cpu_busy_q <= 1'b1;
          end
        end
        RD_PEND: begin
          cpu_busy_q <= 1'b1;
          if (rd_svc) begin
            state_q       <= RD_DATA;
            cpu_q_q       <= ram_rdata;
            cpu_q_valid_q <= 1'b1;
          end
        end
        RD_DATA: begin
          state_q    <= IDLE;
          cpu_busy_q <= (cnt_d == FULL_CNT);
        end
        default: begin
          state_q    <= IDLE;
          cpu_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_q          = cpu_q_q;
  assign cpu_q_valid    = cpu_q_valid_q;
  assign cpu_busy       = cpu_busy_q;
  assign err_drop       = err_drop_q;
  assign asic_ram_q     = asic_ram_q_q;
  assign asic_ram_q_vld = asic_ram_q_vld_q;

endmodule

// File: tb/tb_gx4000_asic_ram_port.sv
// Scoreboard bench for gx4000_asic_ram_port: stimulus pushes expected bytes, a negedge
// monitor pops them whenever cpu_q_valid or asic_ram_q_vld is presented.
module tb_gx4000_asic_ram_port;
  logic        clk_sys = 1'b0;
  logic        reset, asic_unlocked;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_wr, cpu_rd;
  logic [7:0]  cpu_q;
  logic        cpu_q_valid, cpu_busy, err_drop;
  logic [13:0] asic_ram_addr;
  logic        asic_ram_rd, asic_ram_wr;
  logic [7:0]  asic_ram_din, asic_ram_q;
  logic        asic_ram_q_vld;

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;
  logic [7:0] cpu_exp[$];
  logic [7:0] sp_exp[$];

  always #5 clk_sys = ~clk_sys;

  gx4000_asic_ram_port dut (
    .clk_sys(clk_sys), .reset(reset), .asic_unlocked(asic_unlocked),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .cpu_q(cpu_q), .cpu_q_valid(cpu_q_valid), .cpu_busy(cpu_busy), .err_drop(err_drop),
    .asic_ram_addr(asic_ram_addr), .asic_ram_rd(asic_ram_rd), .asic_ram_wr(asic_ram_wr),
    .asic_ram_din(asic_ram_din), .asic_ram_q(asic_ram_q), .asic_ram_q_vld(asic_ram_q_vld)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk_sys) begin
    if (!done) begin
      if (asic_ram_q_vld === 1'b1) begin
        if (sp_exp.size() == 0) chk("sprite_unexpected_vld", 16'(asic_ram_q), 16'hFFFF);
        else chk("sprite_q", 16'(asic_ram_q), 16'(sp_exp.pop_front()));
      end
      if (cpu_q_valid === 1'b1) begin
        if (cpu_exp.size() == 0) chk("cpu_unexpected_valid", 16'(cpu_q), 16'hFFFF);
        else chk("cpu_q", 16'(cpu_q), 16'(cpu_exp.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_cpu(input string nm);
    int n = 0;
    int t = 0;
    while (cpu_busy && t < 100) begin
      if (cpu_q_valid) n++;
      tick;
      t++;
    end
    chk({nm, "_timeout"}, 16'(t < 100), 16'd1);
    chk({nm, "_pulses"}, 16'(n), 16'd1);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_data = d; cpu_wr = 1'b1;
    tick;
    cpu_wr = 1'b0;
    tick;
  endtask

  task automatic cpu_read(input string nm, input logic [15:0] a, input logic [7:0] e);
    cpu_addr = a; cpu_rd = 1'b1;
    cpu_exp.push_back(e);
    tick;
    cpu_rd = 1'b0;
    wait_cpu(nm);
  endtask

  task automatic sp_write(input logic [13:0] a, input logic [7:0] d);
    asic_ram_addr = a; asic_ram_din = d; asic_ram_wr = 1'b1;
    tick;
    asic_ram_wr = 1'b0;
  endtask

  task automatic sp_read(input logic [13:0] a, input logic [7:0] e);
    asic_ram_addr = a; asic_ram_rd = 1'b1;
    sp_exp.push_back(e);
    tick;
    chk("sp_latency", 16'(asic_ram_q_vld), 16'd1);
    asic_ram_rd = 1'b0;
  endtask

  initial begin
    reset = 1'b1; asic_unlocked = 1'b1;
    cpu_addr = '0; cpu_data = '0; cpu_wr = 1'b0; cpu_rd = 1'b0;
    asic_ram_addr = '0; asic_ram_rd = 1'b0; asic_ram_wr = 1'b0; asic_ram_din = '0;
    tick; tick; tick;
    chk("rst_cpu_q", 16'(cpu_q), 16'h0);
    chk("rst_cpu_q_valid", 16'(cpu_q_valid), 16'h0);
    chk("rst_busy", 16'(cpu_busy), 16'h0);
    chk("rst_err_drop", 16'(err_drop), 16'h0);
    chk("rst_sp_q", 16'(asic_ram_q), 16'h0);
    chk("rst_sp_vld", 16'(asic_ram_q_vld), 16'h0);
    reset = 1'b0;
    tick;

    // T1/T2: pattern nibble and full-byte storage, region boundary, window top
    cpu_write(16'h4010, 8'hA5);
    cpu_read("t1_rd", 16'h4010, 8'h05);
    cpu_write(16'h6004, 8'h3C);
    cpu_read("t2_rd", 16'h6004, 8'h3C);
    cpu_write(16'h4FFF, 8'hE7);
    cpu_write(16'h5000, 8'hE7);
    cpu_read("pat_top", 16'h4FFF, 8'h07);
    cpu_read("pat_above", 16'h5000, 8'hE7);
    cpu_write(16'h4000, 8'h0A);
    cpu_write(16'h7FFF, 8'hC3);
    cpu_read("win_top", 16'h7FFF, 8'hC3);

    // out-of-window strobes are ignored, no wrap into offset 0
    cpu_write(16'h8000, 8'h99);
    cpu_write(16'h3FFF, 8'h98);
    chk("oow_busy", 16'(cpu_busy), 16'h0);
    chk("oow_err", 16'(err_drop), 16'h0);

    // T5: locked ASIC page
    asic_unlocked = 1'b0;
    cpu_write(16'h4000, 8'hFF);
    chk("t5_busy", 16'(cpu_busy), 16'h0);
    cpu_addr = 16'h4000; cpu_rd = 1'b1;
    tick;
    cpu_rd = 1'b0;
    chk("t5_rd_busy", 16'(cpu_busy), 16'h0);
    tick;
    chk("t5_err", 16'(err_drop), 16'h0);
    asic_unlocked = 1'b1;
    cpu_read("t5_ram", 16'h4000, 8'h0A);
    cpu_read("oow_nowrap", 16'h7FFF, 8'hC3);

    // sprite port: pattern masking and read-before-write
    sp_write(14'h0005, 8'hAB);
    sp_read(14'h0005, 8'h0B);
    sp_write(14'h2100, 8'h77);
    asic_ram_addr = 14'h2100; asic_ram_din = 8'h88;
    asic_ram_rd = 1'b1; asic_ram_wr = 1'b1;
    sp_exp.push_back(8'h77);
    tick;
    asic_ram_rd = 1'b0; asic_ram_wr = 1'b0;
    sp_read(14'h2100, 8'h88);

    // T3: sprite reads every cycle; FIFO fills and must not drain until traffic stops
    for (int i = 0; i < 20; i++) sp_write(14'h2000 + 14'(i), 8'(i * 7 + 3));
    cpu_write(16'h6100, 8'h00);
    cpu_write(16'h6101, 8'h00);
    cpu_write(16'h6102, 8'h44);
    for (int i = 0; i < 20; i++) begin
      asic_ram_rd = 1'b1; asic_ram_addr = 14'h2000 + 14'(i);
      sp_exp.push_back(8'(i * 7 + 3));
      cpu_wr   = (i == 1) || (i == 2) || (i == 4);
      cpu_addr = (i == 1) ? 16'h6100 : (i == 2) ? 16'h6101 : 16'h6102;
      cpu_data = (i == 1) ? 8'h11 : (i == 2) ? 8'h22 : 8'h33;
      tick;
      chk("t3_vld", 16'(asic_ram_q_vld), 16'd1);
      if (i == 4) begin
        chk("t3_busy_full", 16'(cpu_busy), 16'd1);
        chk("t3_err_drop", 16'(err_drop), 16'd1);
      end
    end
    asic_ram_rd = 1'b0; cpu_wr = 1'b0;
    chk("t3_no_drain", 16'(cpu_busy), 16'd1);
    tick; tick;
    chk("t3_drained", 16'(cpu_busy), 16'd0);
    cpu_read("t3_a", 16'h6100, 8'h11);
    cpu_read("t3_b", 16'h6101, 8'h22);
    cpu_read("t3_dropped", 16'h6102, 8'h44);

    // T4: write then read of same byte behind sprite traffic
    cpu_write(16'h6200, 8'h00);
    for (int i = 0; i < 8; i++) begin
      asic_ram_rd = 1'b1; asic_ram_addr = 14'h2000 + 14'(i);
      sp_exp.push_back(8'(i * 7 + 3));
      cpu_addr = 16'h6200; cpu_data = 8'h5A;
      cpu_wr = (i == 0);
      cpu_rd = (i == 2);
      if (i == 2) cpu_exp.push_back(8'h5A);
      tick;
      if (i >= 3) chk("t4_pending", 16'(cpu_busy), 16'd1);
    end
    asic_ram_rd = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0;
    wait_cpu("t4_rd");

    // T6: reset while a read is pending
    cpu_write(16'h6300, 8'h66);
    asic_ram_rd = 1'b1; asic_ram_addr = 14'h2003;
    sp_exp.push_back(8'(3 * 7 + 3));
    cpu_addr = 16'h6300; cpu_rd = 1'b1;
    tick;
    cpu_rd = 1'b0;
    chk("t6_busy_pend", 16'(cpu_busy), 16'd1);
    asic_ram_addr = 14'h2004;
    sp_exp.push_back(8'(4 * 7 + 3));
    tick;
    asic_ram_rd = 1'b0; reset = 1'b1;
    tick;
    chk("t6_busy", 16'(cpu_busy), 16'd0);
    chk("t6_valid", 16'(cpu_q_valid), 16'd0);
    chk("t6_err", 16'(err_drop), 16'd0);
    chk("t6_sp_q", 16'(asic_ram_q), 16'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    cpu_read("t6_ram", 16'h6300, 8'h66);

    // simultaneous wr+rd: write taken, read dropped and flagged
    cpu_addr = 16'h6400; cpu_data = 8'h5E; cpu_wr = 1'b1; cpu_rd = 1'b1;
    tick;
    cpu_wr = 1'b0; cpu_rd = 1'b0;
    chk("wrrd_err", 16'(err_drop), 16'd1);
    tick; tick;
    cpu_read("wrrd_wr", 16'h6400, 8'h5E);

    tick; tick;
    done = 1'b1;
    chk("cpu_queue_empty", 16'(cpu_exp.size()), 16'd0);
    chk("sp_queue_empty", 16'(sp_exp.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
